des_dec_keysched: RTL and testbench
===================================

DES_DEC_KEYSCHED -- requirements
Module: des_dec_keysched

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port key_in, input, [1:64]: 64-bit DES key, FIPS 46 bit order (bit 1 = MSB); parity bits 8,16,...,64 are ignored.
REQ-004 SHALL have port key_valid, input, 1 bit: key_in is offered.
REQ-005 SHALL have port key_ready, output, 1 bit: block can accept a key.
REQ-006 SHALL have port subkey_out, output, [1:48]: current round subkey, PC-2 output order.
REQ-007 SHALL have port subkey_valid, output, 1 bit: subkey_out holds a valid subkey.
REQ-008 SHALL have port subkey_ready, input, 1 bit: downstream consumes the subkey.
REQ-009 SHALL have port round_idx, output, [3:0]: DES round number of subkey_out minus 1 (K16 -> 15).
REQ-010 SHALL have port last, output, 1 bit: high with the final subkey of a sequence.

Function
REQ-011 SHALL implement states IDLE and RUN.
REQ-012 In IDLE, key_ready SHALL be 1 and subkey_valid SHALL be 0.
REQ-013 A key is accepted when key_valid && key_ready at a rising edge; C,D registers SHALL load PC-1(key_in), and the state SHALL go to RUN.
REQ-014 In RUN, key_ready SHALL be 0, and key_valid SHALL be ignored without affecting any state.
REQ-015 The first subkey (K16 = PC-2(C0,D0), unrotated) SHALL be valid in the cycle after acceptance: a latency of 1 cycle.
REQ-016 subkey_out is combinational PC-2 of the registered C,D.
REQ-017 A subkey is consumed when subkey_valid && subkey_ready at a rising edge.
REQ-018 On consumption, C and D SHALL each rotate RIGHT by the decryption shift for the next round.
  - Shift sequence after K16, K15, ..., K2: 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-019 round_idx SHALL start at 15 and decrement by 1 per consumption.
REQ-020 Without consumption, subkey_out, subkey_valid and round_idx SHALL hold stable, with no bound on the stall length.
REQ-021 last SHALL equal subkey_valid && round_idx==0.
REQ-022 On consumption of the last subkey, the state SHALL return to IDLE, key_ready SHALL be 1 the next cycle, and C,D SHALL equal PC-1 rotated totals of 28, i.e. unchanged from load.
REQ-023 A new key SHALL NOT be accepted in the same cycle as the last consumption; the minimum gap is 1 IDLE cycle.
REQ-024 Throughput SHALL be 1 subkey per cycle when subkey_ready is held at 1, i.e. 17 cycles per key including the IDLE cycle.

Reset
REQ-025 While rst_n=0, the block SHALL force IDLE with key_ready=1, subkey_valid=0, last=0, round_idx=0, and C=D=0, so subkey_out=0.
REQ-026 Assertion of rst_n mid-sequence SHALL abort the sequence immediately; no further subkeys SHALL be issued.
REQ-027 The first key SHALL be acceptable on the first rising edge after rst_n deasserts.

Configuration
REQ-028 With DES_KS_ENC_MODE_EN defined, an input enc (1 bit) SHALL be sampled at key acceptance.
  - enc=1: issue K1..K16 using left rotations 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, with the rotation applied before each subkey, and round_idx counting 0 up to 15.
  - last SHALL then be subkey_valid && round_idx==15.
  - enc=0: behaviour per REQ-015..REQ-024.
REQ-029 Without DES_KS_ENC_MODE_EN, port enc SHALL be absent and the block SHALL be decryption-order only.

Verification
REQ-030 Reset, then key_in=64'h133457799BBCDFF1 and key_valid pulse, subkey_ready=1 -> next cycle subkey_out=48'hCB3D8B0E17F5, round_idx=15; 16th subkey=48'h1B02EFFC7072, round_idx=0, last=1.
REQ-031 Same key with subkey_ready low for 5 cycles at round_idx=10 -> subkey_out and round_idx stable for all 5 cycles; the remaining sequence is identical to the unstalled run.
REQ-032 key_valid held high throughout a sequence with a different key_in -> no reload; output sequence unchanged; second key accepted only after key_ready rises.
REQ-033 rst_n pulsed low at round_idx=7 -> subkey_valid=0 and key_ready=1 asynchronously; a following key produces a correct full sequence starting from K16.
REQ-034 Key 64'h0000000000000000 versus 64'h0101010101010101 (parity-only difference) -> identical 16 subkeys, all 48'h0.
REQ-035 With DES_KS_ENC_MODE_EN and enc=1, key 64'h133457799BBCDFF1 -> first subkey 48'h1B02EFFC7072 with round_idx=0; last subkey 48'hCB3D8B0E17F5.

Source files
------------

// File: rtl/des_dec_keysched.sv
// DES key schedule: issues round subkeys K16..K1 for decryption, one per handshake.
// Define DES_KS_ENC_MODE_EN to add an enc input that selects K1..K16 order.
module des_dec_keysched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:64] key_in,
    input  logic        key_valid,
`ifdef DES_KS_ENC_MODE_EN
    input  logic        enc,
`endif
    output logic        key_ready,
    output logic [1:48] subkey_out,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round_idx,
    output logic        last
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // FIPS bit p (1 = MSB) of an N-bit vector sits at index N-p here.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++)
            r[6'(55 - i)] = k[6'(64 - PC1[i])];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++)
            r[6'(47 - i)] = cd[6'(56 - PC2[i])];
        return r;
    endfunction

    // Rounds 1, 2, 9 and 16 shift by one, all others by two.
    function automatic logic shift2(input logic [3:0] idx);
        return !(idx == 4'd0 || idx == 4'd1 || idx == 4'd8 || idx == 4'd15);
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] v, input logic two);
        return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
        return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
    endfunction

    state_t      state_q;
    state_t      state_d;
    logic [27:0] c_q;
    logic [27:0] d_q;
    logic [55:0] cd_load;
    logic        accept;
    logic        consume;
    logic        fin;
    logic        enc_sel;
    logic        enc_q;

`ifdef DES_KS_ENC_MODE_EN
    assign enc_sel = enc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            enc_q <= 1'b0;
        else if (accept)
            enc_q <= enc;
    end
`else
    assign enc_sel = 1'b0;
    assign enc_q   = 1'b0;
`endif

    assign cd_load    = pc1(key_in);
    assign subkey_out = pc2({c_q, d_q});
    assign fin        = (round_idx == (enc_q ? 4'd15 : 4'd0));
    assign last       = subkey_valid && fin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        key_ready    = 1'b0;
        subkey_valid = 1'b0;
        accept       = 1'b0;
        consume      = 1'b0;
        unique case (state_q)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                subkey_valid = 1'b1;
                if (subkey_ready) begin
                    consume = 1'b1;
                    if (fin)
                        state_d = IDLE;
                end
            end
        endcase
    end

    // Decryption walks back with right rotations; 28 in total restores C0,D0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q       <= '0;
            d_q       <= '0;
            round_idx <= '0;
        end else if (accept) begin
            if (enc_sel) begin
                c_q       <= rotl(cd_load[55:28], 1'b0);
                d_q       <= rotl(cd_load[27:0], 1'b0);
                round_idx <= 4'd0;
            end else begin
                c_q       <= cd_load[55:28];
                d_q       <= cd_load[27:0];
                round_idx <= 4'd15;
            end
        end else if (consume) begin
            if (enc_q) begin
                if (!fin) begin
                    c_q       <= rotl(c_q, shift2(4'(round_idx + 4'd1)));
                    d_q       <= rotl(d_q, shift2(4'(round_idx + 4'd1)));
                    round_idx <= 4'(round_idx + 4'd1);
                end
            end else begin
                c_q <= rotr(c_q, shift2(round_idx));
                d_q <= rotr(d_q, shift2(round_idx));
                if (!fin)
                    round_idx <= 4'(round_idx - 4'd1);
            end
        end
    end

endmodule

// File: tb/tb_des_dec_keysched.sv
// Bench for des_dec_keysched: scoreboard of subkeys from a forward DES key-schedule model.
module tb_des_dec_keysched;

    logic        clk;
    logic        rst_n;
    logic [1:64] key_in;
    logic        key_valid;
    logic        key_ready;
    logic [1:48] subkey_out;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round_idx;
    logic        last;
`ifdef DES_KS_ENC_MODE_EN
    logic        enc;
`endif

    des_dec_keysched dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_in       (key_in),
        .key_valid    (key_valid),
`ifdef DES_KS_ENC_MODE_EN
        .enc          (enc),
`endif
        .key_ready    (key_ready),
        .subkey_out   (subkey_out),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round_idx    (round_idx),
        .last         (last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;

    typedef struct {
        logic [47:0] sk;
        logic [3:0]  idx;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    logic        stall_prev = 1'b0;
    logic [47:0] prev_sk;
    logic [3:0]  prev_idx;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Forward schedule: Kr after r cumulative left shifts of PC-1 halves.
    function automatic logic [47:0] model_k(input logic [63:0] key, input int r);
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        logic [47:0] k;
        cd = '0;
        k  = '0;
        for (int i = 0; i < 56; i++)
            cd[6'(55 - i)] = key[6'(64 - PC1[i])];
        c = cd[55:28];
        d = cd[27:0];
        for (int j = 0; j < r; j++)
            for (int n = 0; n < SHIFTS[j]; n++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
        cd = {c, d};
        for (int i = 0; i < 48; i++)
            k[6'(47 - i)] = cd[6'(56 - PC2[i])];
        return k;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_sk", 64'(subkey_out), 64'(prev_sk));
                chk("stall_idx", 64'(round_idx), 64'(prev_idx));
            end
            stall_prev = 1'b0;
            chk("key_ready", 64'(key_ready), 64'(q.size() == 0));
            chk("subkey_valid", 64'(subkey_valid), 64'(q.size() != 0));
            if (subkey_valid && q.size() > 0) begin
                if (subkey_ready) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("subkey", 64'(subkey_out), 64'(e.sk));
                    chk("round_idx", 64'(round_idx), 64'(e.idx));
                    chk("last", 64'(last), 64'(e.idx == 4'd0));
                end else begin
                    chk("last_hold", 64'(last), 64'(q[0].idx == 4'd0));
                    stall_prev = 1'b1;
                    prev_sk    = subkey_out;
                    prev_idx   = round_idx;
                end
            end
            if (key_valid && key_ready)
                for (int r = 16; r >= 1; r--)
                    q.push_back('{model_k(key_in, r), 4'(r - 1)});
        end
    end

    task automatic start_key(input logic [63:0] k);
        key_in    = k;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (q.size() == 0 && key_ready)
                done = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        if (!done)
            chk(tag, 64'd0, 64'd1);
    endtask

    task automatic wait_idx(input logic [3:0] target, input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (subkey_valid && round_idx == target)
                done = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        if (!done)
            chk(tag, 64'd0, 64'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        key_in       = '0;
        key_valid    = 1'b0;
        subkey_ready = 1'b0;
`ifdef DES_KS_ENC_MODE_EN
        enc          = 1'b0;
`endif
        #1;
        chk("rst_key_ready", 64'(key_ready), 64'd1);
        chk("rst_valid", 64'(subkey_valid), 64'd0);
        chk("rst_last", 64'(last), 64'd0);
        chk("rst_idx", 64'(round_idx), 64'd0);
        chk("rst_subkey", 64'(subkey_out), 64'd0);
        repeat (2) @(posedge clk);
        #1;

        // Unstalled run; key offered on the first edge after reset release.
        rst_n        = 1'b1;
        subkey_ready = 1'b1;
        start_key(KEY_A);
        chk("first_k16", 64'(subkey_out), 64'h0000CB3D8B0E17F5);
        chk("first_idx", 64'(round_idx), 64'd15);
        repeat (15) begin
            @(posedge clk); #1;
        end
        chk("k1", 64'(subkey_out), 64'h00001B02EFFC7072);
        chk("k1_idx", 64'(round_idx), 64'd0);
        chk("k1_last", 64'(last), 64'd1);
        @(posedge clk); #1;
        chk("idle_after", 64'(key_ready), 64'd1);

        // Five-cycle stall at round_idx 10.
        start_key(KEY_A);
        wait_idx(4'd10, "stall_reach");
        subkey_ready = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        subkey_ready = 1'b1;
        wait_idle("stall_done");

        // key_valid held with a changed key while running.
        key_in    = KEY_A;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_in = KEY_B;
        chk("run_no_ready", 64'(key_ready), 64'd0);
        wait_idle("hold_first");
        @(posedge clk); #1;
        key_valid = 1'b0;
        chk("second_k16", 64'(subkey_out), 64'(model_k(KEY_B, 16)));
        wait_idle("hold_second");

        // Abort by reset at round_idx 7.
        start_key(KEY_A);
        wait_idx(4'd7, "abort_reach");
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("abort_valid", 64'(subkey_valid), 64'd0);
        chk("abort_ready", 64'(key_ready), 64'd1);
        chk("abort_subkey", 64'(subkey_out), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        start_key(KEY_A);
        chk("restart_k16", 64'(subkey_out), 64'h0000CB3D8B0E17F5);
        chk("restart_idx", 64'(round_idx), 64'd15);
        wait_idle("restart_done");

        // Parity-only key differences give all-zero subkeys.
        start_key(64'h0000000000000000);
        chk("zero_key", 64'(subkey_out), 64'd0);
        wait_idle("zero_done");
        start_key(64'h0101010101010101);
        chk("parity_key", 64'(subkey_out), 64'd0);
        wait_idle("parity_done");

        // Random keys under random back-pressure.
        for (int t = 0; t < 3; t++) begin
            start_key({$urandom, $urandom});
            for (int i = 0; i < 200 && !(q.size() == 0 && key_ready); i++) begin
                subkey_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            subkey_ready = 1'b1;
            wait_idle("rand_done");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
